mult_session_ctrl: RTL and testbench

MULT_SESSION_CTRL -- requirements
Module: mult_session_ctrl

---
 rtl/mult_ui_pkg.sv | 26 ++
 rtl/mult_session_ctrl_if.sv | 32 +++
 rtl/scroll_counter.sv | 67 ++++++
 rtl/mult_session_ctrl.sv | 126 ++++++++++++
 tb/tb_mult_session_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_ui_pkg.sv
// Shared definitions for the multiplier session controller.
//   state_e       : controller states (idle, launch, wait, show)
//   Def*          : default operand width, product digit count, visible window size
//   scroll_width(): bit width of a scroll position for a given digit/window count
package mult_ui_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StWait,
      StShow
   } state_e;

   localparam int unsigned DefWidth  = 8;
   localparam int unsigned DefDigits = 5;
   localparam int unsigned DefWindow = 3;

   // Positions run 0..digits-window; never narrower than one bit.
   function automatic int unsigned scroll_width(input int unsigned digits,
                                                input int unsigned window);
      int unsigned span;
      span = digits - window + 1;
      return (span > 1) ? $clog2(span) : 1;
   endfunction

endpackage

// File: rtl/mult_session_ctrl_if.sv
// Handshake between the session controller and an external multiplier.
//   master (controller): drives mult_start, mult_a, mult_b; receives mult_done, mult_product
//   slave  (multiplier): the reverse
interface mult_session_ctrl_if
   import mult_ui_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) ();

   logic                 mult_start;
   logic [WIDTH-1:0]     mult_a;
   logic [WIDTH-1:0]     mult_b;
   logic                 mult_done;
   logic [2*WIDTH-1:0]   mult_product;

   modport master (
      output mult_start,
      output mult_a,
      output mult_b,
      input  mult_done,
      input  mult_product
   );

   modport slave (
      input  mult_start,
      input  mult_a,
      input  mult_b,
      output mult_done,
      output mult_product
   );

endinterface

// File: rtl/scroll_counter.sv
// Window offset counter for the product display.
//   clk, rst : clock, asynchronous active-high reset
//   inc, dec : step right / left (both together cancel)
//   clr      : force position 0 (has priority)
//   en       : steps are only honoured while high
//   pos      : current offset, 0 .. DIGITS-WINDOW
// Build option: define SCROLL_WRAP_EN to wrap at the ends instead of saturating.
module scroll_counter
   import mult_ui_pkg::*;
#(
   parameter int unsigned DIGITS = DefDigits,
   parameter int unsigned WINDOW = DefWindow
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        inc,
   input  logic                                        dec,
   input  logic                                        clr,
   input  logic                                        en,
   output logic [scroll_width(DIGITS, WINDOW)-1:0]     pos
);

   localparam int unsigned     PosW   = scroll_width(DIGITS, WINDOW);
   localparam logic [PosW-1:0] MaxPos = PosW'(DIGITS - WINDOW);

   logic [PosW-1:0] pos_q, pos_d;

   always_comb begin
      pos_d = pos_q;
      if (clr) begin
         pos_d = '0;
      end else if (en && (inc != dec)) begin
         if (inc) begin
            if (pos_q == MaxPos) begin
`ifdef SCROLL_WRAP_EN
               pos_d = '0;
`else
               pos_d = MaxPos;
`endif
            end else begin
               pos_d = pos_q + 1'b1;
            end
         end else begin
            if (pos_q == '0) begin
`ifdef SCROLL_WRAP_EN
               pos_d = MaxPos;
`else
               pos_d = '0;
`endif
            end else begin
               pos_d = pos_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= '0;
      end else begin
         pos_q <= pos_d;
      end
   end

   assign pos = pos_q;

endmodule

// File: rtl/mult_session_ctrl.sv
// Session controller: latches switch operands, launches an external multiplier, waits for its
// result with a timeout, then holds the product for a scrollable digit display.
//   clk, rst                  : clock, asynchronous active-high reset
//   start_tick                : launch (ignored while a launch is in flight)
//   left_tick, right_tick     : scroll the display window while a result is shown
//   sw_a, sw_b                : signed operands from switches
//   mult_if (master)          : mult_start/mult_a/mult_b out, mult_done/mult_product in
//   product, result_valid     : captured product and its freshness flag
//   busy                      : a launch is in flight
//   timeout_err               : sticky, the last launch got no answer in time
//   scroll_pos                : display window offset, 0 = most-significant window
// Build option: SCROLL_WRAP_EN makes the scroll position wrap instead of saturate.
module mult_session_ctrl
   import mult_ui_pkg::*;
#(
   parameter int unsigned WIDTH       = DefWidth,
   parameter int unsigned DIGITS      = DefDigits,
   parameter int unsigned WINDOW      = DefWindow,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      start_tick,
   input  logic                                      left_tick,
   input  logic                                      right_tick,
   input  logic [WIDTH-1:0]                          sw_a,
   input  logic [WIDTH-1:0]                          sw_b,
   mult_session_ctrl_if.master                       mult_if,
   output logic [2*WIDTH-1:0]                        product,
   output logic                                      result_valid,
   output logic                                      busy,
   output logic                                      timeout_err,
   output logic [scroll_width(DIGITS, WINDOW)-1:0]   scroll_pos
);

   localparam int unsigned     CntW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);

   state_e               state_q;
   logic [CntW-1:0]      wait_cnt_q;
   logic                 mult_start_q;
   logic [WIDTH-1:0]     a_q;
   logic [WIDTH-1:0]     b_q;
   logic [2*WIDTH-1:0]   product_q;
   logic                 valid_q;
   logic                 busy_q;
   logic                 timeout_q;

   logic capture;
   logic scroll_en;

   assign capture   = (state_q == StWait) && mult_if.mult_done;
   // A start in SHOW takes priority over any scroll tick in the same cycle.
   assign scroll_en = (state_q == StShow) && !start_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         wait_cnt_q   <= '0;
         mult_start_q <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         product_q    <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         mult_start_q <= 1'b0;
         unique case (state_q)
            StIdle, StShow: begin
               if (start_tick) begin
                  a_q          <= sw_a;
                  b_q          <= sw_b;
                  valid_q      <= 1'b0;
                  timeout_q    <= 1'b0;
                  mult_start_q <= 1'b1;
                  busy_q       <= 1'b1;
                  state_q      <= StLaunch;
               end
            end
            StLaunch: begin
               wait_cnt_q <= '0;
               state_q    <= StWait;
            end
            StWait: begin
               // A done on the final count still counts as success.
               if (mult_if.mult_done) begin
                  product_q <= mult_if.mult_product;
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StShow;
               end else if (wait_cnt_q == TimeoutVal) begin
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   scroll_counter #(
      .DIGITS (DIGITS),
      .WINDOW (WINDOW)
   ) u_scroll (
      .clk (clk),
      .rst (rst),
      .inc (right_tick),
      .dec (left_tick),
      .clr (capture),
      .en  (scroll_en),
      .pos (scroll_pos)
   );

   assign mult_if.mult_start = mult_start_q;
   assign mult_if.mult_a     = a_q;
   assign mult_if.mult_b     = b_q;
   assign product            = product_q;
   assign result_valid       = valid_q;
   assign busy               = busy_q;
   assign timeout_err        = timeout_q;

endmodule

// File: tb/tb_mult_session_ctrl.sv
// Bench for mult_session_ctrl: directed scenarios with literal expectations, then a random phase,
// all checked every cycle against a transaction-level model of the session.
module tb_mult_session_ctrl;

   localparam int W    = 8;
   localparam int D    = 5;
   localparam int WN   = 3;
   localparam int TO   = 64;
   localparam int PMAX = D - WN;
`ifdef SCROLL_WRAP_EN
   localparam bit Wrap = 1'b1;
`else
   localparam bit Wrap = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_tick = 1'b0;
   logic          left_tick = 1'b0;
   logic          right_tick = 1'b0;
   logic [W-1:0]  sw_a = '0;
   logic [W-1:0]  sw_b = '0;
   logic [2*W-1:0] product;
   logic          result_valid;
   logic          busy;
   logic          timeout_err;
   logic [1:0]    scroll_pos;

   mult_session_ctrl_if #(.WIDTH(W)) mif ();

   mult_session_ctrl #(
      .WIDTH       (W),
      .DIGITS      (D),
      .WINDOW      (WN),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_tick   (start_tick),
      .left_tick    (left_tick),
      .right_tick   (right_tick),
      .sw_a         (sw_a),
      .sw_b         (sw_b),
      .mult_if      (mif),
      .product      (product),
      .result_valid (result_valid),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .scroll_pos   (scroll_pos)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Session model: a launch is "pending" for one cycle, then "in flight" for an age in cycles.
   bit           m_pending;
   int           m_age;       // -1 when nothing in flight
   bit           m_show;
   bit           m_rv;
   bit           m_to;
   logic [W-1:0] m_a;
   logic [W-1:0] m_b;
   logic [2*W-1:0] m_prod;
   int           m_pos;

   // Multiplier stand-in.
   int           resp_delay = 8;
   int           resp_cnt = -1;
   logic [2*W-1:0] resp_prod;
   bit           noise_en = 1'b0;
   int           start_pulses = 0;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pending = 0; m_age = -1; m_show = 0; m_rv = 0; m_to = 0;
      m_a = '0; m_b = '0; m_prod = '0; m_pos = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if ((m_show || (!m_pending && m_age < 0)) && start_tick) begin
         m_a = sw_a; m_b = sw_b; m_to = 0; m_rv = 0; m_show = 0; m_pending = 1;
      end else if (m_pending) begin
         m_pending = 0; m_age = 0;
      end else if (m_age >= 0) begin
         if (mif.mult_done) begin
            m_prod = mif.mult_product; m_rv = 1; m_pos = 0; m_show = 1; m_age = -1;
         end else if (m_age == TO) begin
            m_to = 1; m_age = -1;
         end else begin
            m_age++;
         end
      end else if (m_show && (left_tick != right_tick)) begin
         if (right_tick) m_pos = (m_pos == PMAX) ? (Wrap ? 0 : PMAX) : m_pos + 1;
         else            m_pos = (m_pos == 0) ? (Wrap ? PMAX : 0) : m_pos - 1;
      end
   endtask

   task automatic check_all();
      if (rst) model_reset();
      cmp("mult_start",   mif.mult_start, m_pending);
      cmp("mult_a",       mif.mult_a, m_a);
      cmp("mult_b",       mif.mult_b, m_b);
      cmp("product",      product, m_prod);
      cmp("result_valid", result_valid, m_rv);
      cmp("busy",         busy, (m_pending || m_age >= 0));
      cmp("timeout_err",  timeout_err, m_to);
      cmp("scroll_pos",   scroll_pos, m_pos);
   endtask

   // One clock: compare at the falling edge, drive the multiplier, update the model at the rise.
   task automatic step();
      logic signed [2*W-1:0] ea, eb;
      @(negedge clk);
      check_all();
      if (mif.mult_start) start_pulses++;
      mif.mult_done = 1'b0;
      if (resp_cnt > 0) resp_cnt--;
      if (resp_cnt == 0) begin
         mif.mult_done = 1'b1;
         mif.mult_product = resp_prod;
         resp_cnt = -1;
      end else if (noise_en && $urandom_range(0, 15) == 0) begin
         mif.mult_done = 1'b1;
         mif.mult_product = 16'($urandom);
      end
      if (mif.mult_start && resp_delay >= 0) begin
         ea = $signed(mif.mult_a);
         eb = $signed(mif.mult_b);
         resp_prod = ea * eb;
         resp_cnt = resp_delay;
      end
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic wait_rv(input int budget, output int n);
      n = 0;
      while (!result_valid && n < budget) begin
         step();
         n++;
      end
      cmp("wait_result_valid", result_valid, 1);
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (busy && n < budget) begin
         step();
         n++;
      end
      cmp("wait_not_busy", busy, 0);
   endtask

   task automatic lit_all_zero(input string tag);
      cmp({tag, "_mult_start"}, mif.mult_start, 0);
      cmp({tag, "_mult_a"}, mif.mult_a, 0);
      cmp({tag, "_mult_b"}, mif.mult_b, 0);
      cmp({tag, "_product"}, product, 0);
      cmp({tag, "_result_valid"}, result_valid, 0);
      cmp({tag, "_busy"}, busy, 0);
      cmp({tag, "_timeout_err"}, timeout_err, 0);
      cmp({tag, "_scroll_pos"}, scroll_pos, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_r[3];
      exp_r[0] = 1; exp_r[1] = 2; exp_r[2] = Wrap ? 0 : 2;
      mif.mult_done = 1'b0;
      mif.mult_product = '0;
      model_reset();

      // Reset state.
      rst = 1'b1;
      step(); step();
      lit_all_zero("reset");
      rst = 1'b0;
      step();

      // -7 * 5, multiplier answers 8 cycles after the launch pulse.
      sw_a = 8'hF9; sw_b = 8'h05; start_pulses = 0;
      start_tick = 1'b1; step(); start_tick = 1'b0;
      cmp("t1_start_next_cycle", mif.mult_start, 1);
      step();
      cmp("t1_start_one_cycle", mif.mult_start, 0);
      wait_rv(40, n);
      cmp("t1_latency", n, 8);
      cmp("t1_product", product, 16'hFFDD);
      cmp("t1_scroll", scroll_pos, 0);
      cmp("t1_pulses", start_pulses, 1);

      // Three right scrolls, then back to position 1, then both ticks together.
      for (int i = 0; i < 3; i++) begin
         right_tick = 1'b1; step(); right_tick = 1'b0;
         cmp($sformatf("t2_right_%0d", i), scroll_pos, exp_r[i]);
         step();
      end
      if (Wrap) right_tick = 1'b1; else left_tick = 1'b1;
      step(); right_tick = 1'b0; left_tick = 1'b0;
      cmp("t2_back_to_1", scroll_pos, 1);
      left_tick = 1'b1; right_tick = 1'b1; step();
      left_tick = 1'b0; right_tick = 1'b0;
      cmp("t2_both_ticks", scroll_pos, 1);
      left_tick = 1'b1; step(); step(); left_tick = 1'b0;
      cmp("t2_left_bound", scroll_pos, Wrap ? 2 : 0);

      // No answer at all: timeout after the final count.
      resp_delay = -1;
      start_tick = 1'b1; step(); start_tick = 1'b0;
      cmp("t3_busy_launch", busy, 1);
      wait_idle(200, n);
      cmp("t3_busy_cycles", n, 66);
      cmp("t3_timeout_err", timeout_err, 1);
      cmp("t3_result_valid", result_valid, 0);

      // Answer on the final count is a success; one cycle later is a timeout.
      resp_delay = 65;
      start_tick = 1'b1; step(); start_tick = 1'b0;
      wait_idle(200, n);
      cmp("t3_edge_ok_valid", result_valid, 1);
      cmp("t3_edge_ok_to", timeout_err, 0);
      resp_delay = 66;
      start_tick = 1'b1; step(); start_tick = 1'b0;
      wait_idle(200, n);
      cmp("t3_edge_late_to", timeout_err, 1);
      cmp("t3_edge_late_valid", result_valid, 0);
      for (int i = 0; i < 4; i++) step();

      // -128 * -128 with a start ignored mid-wait.
      resp_delay = 8; start_pulses = 0;
      sw_a = 8'h80; sw_b = 8'h80;
      start_tick = 1'b1; step(); start_tick = 1'b0;
      step(); step(); step();
      sw_a = 8'h01; start_tick = 1'b1; step(); start_tick = 1'b0;
      wait_rv(40, n);
      cmp("t4_product", product, 16'h4000);
      cmp("t4_mult_a", mif.mult_a, 8'h80);
      cmp("t4_pulses", start_pulses, 1);

      // Start together with a scroll tick: start wins.
      right_tick = 1'b1; start_tick = 1'b1; step();
      right_tick = 1'b0; start_tick = 1'b0;
      cmp("t5_start_wins_pos", scroll_pos, 0);
      cmp("t5_start_wins_busy", busy, 1);
      cmp("t5_start_wins_valid", result_valid, 0);
      wait_rv(40, n);

      // Reset at wait count 3; the late answer must be ignored.
      start_tick = 1'b1; step(); start_tick = 1'b0;
      step(); step(); step(); step();
      rst = 1'b1; #1;
      lit_all_zero("t6_async");
      step();
      rst = 1'b0;
      for (int i = 0; i < 12; i++) step();
      lit_all_zero("t6_after");

      // Random phase.
      noise_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         int r;
         start_tick = ($urandom_range(0, 9) == 0);
         left_tick  = ($urandom_range(0, 3) == 0);
         right_tick = ($urandom_range(0, 3) == 0);
         sw_a = 8'($urandom);
         sw_b = 8'($urandom);
         rst  = ($urandom_range(0, 399) == 0);
         r = $urandom_range(0, 9);
         if (r < 7)       resp_delay = $urandom_range(1, 20);
         else if (r == 7) resp_delay = 65;
         else if (r == 8) resp_delay = 66;
         else             resp_delay = -1;
         step();
      end
      rst = 1'b0; start_tick = 1'b0; left_tick = 1'b0; right_tick = 1'b0; noise_en = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
